// File: rtl/conv_mac_acc.sv
// conv_mac_acc: pipelined K-tap convolution MAC with cross-beat accumulation,
// bias, output saturation to OW bits and optional ReLU.
module conv_mac_acc #(
  parameter int KN   = 49,
  parameter int WW   = 16,
  parameter int IW   = 8,
  parameter int FRAC = 8,
  parameter int OW   = 16,
  parameter int ACCW = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [WW*KN-1:0]       wei,
  input  logic [IW*KN-1:0]       ima,
  input  logic signed [OW-1:0]   bias,
  input  logic                   relu_en,
  output logic                   out_valid,
  output logic signed [OW-1:0]   out_data,
  output logic                   out_sat,
  output logic                   seq_err
);

  localparam int T  = $clog2(KN);
  localparam int NP = 1 << T;
  localparam int PW = WW + IW + 1;
  localparam int SW = PW + T;

  localparam logic signed [ACCW-1:0] OMAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] OMIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // Weights, bias and accumulator share the same binary point, so no
  // realignment happens anywhere; the accumulator must hold a full tree sum.
  if (KN < 2 || FRAC >= OW || FRAC >= WW || ACCW < SW + 1 || ACCW < OW) begin : g_param_chk
    $error("conv_mac_acc: illegal parameter combination");
  end

  // Signed weight times zero-extended pixel for tap i.
  function automatic logic signed [PW-1:0] tap_mul(input logic [WW*KN-1:0] w,
                                                   input logic [IW*KN-1:0] x,
                                                   input int i);
    logic signed [WW-1:0] ws;
    logic signed [IW:0]   xs;
    ws = w[i*WW +: WW];
    xs = {1'b0, x[i*IW +: IW]};
    tap_mul = PW'(ws) * PW'(xs);
  endfunction

  // Accumulator addition clamped at the ACCW signed limits.
  function automatic logic signed [ACCW-1:0] sat_add(input logic signed [ACCW-1:0] a,
                                                     input logic signed [ACCW-1:0] b);
    logic signed [ACCW:0] s;
    s = {a[ACCW-1], a} + {b[ACCW-1], b};
    if (s[ACCW] != s[ACCW-1])
      sat_add = s[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    else
      sat_add = s[ACCW-1:0];
  endfunction

  // Clamp accumulator to OW bits; returns {sat_flag, value}.
  function automatic logic [OW:0] clamp_ow(input logic signed [ACCW-1:0] a);
    if (a > OMAX)
      clamp_ow = {1'b1, OMAX[OW-1:0]};
    else if (a < OMIN)
      clamp_ow = {1'b1, OMIN[OW-1:0]};
    else
      clamp_ow = {1'b0, a[OW-1:0]};
  endfunction

  // Control/sideband pipeline: index N is stage N (0 = input, 1 = multiply,
  // 2..T+1 = adder tree levels 1..T).
  logic                  vld_p   [0:T+1];
  logic                  first_p [0:T+1];
  logic                  last_p  [0:T+1];
  logic                  relu_p  [0:T+1];
  logic signed [OW-1:0]  bias_p  [0:T+1];
  logic [WW*KN-1:0]      wei_p0;
  logic [IW*KN-1:0]      ima_p0;

  // ---- stage 0: input register; valid shift chain (only valids are reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= T + 1; k++) vld_p[k] <= 1'b0;
    end else begin
      vld_p[0] <= in_valid;
      for (int k = 1; k <= T + 1; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Data and flag sidebands travel with the valid chain, unreset.
  always_ff @(posedge clk) begin
    wei_p0     <= wei;
    ima_p0     <= ima;
    first_p[0] <= in_first;
    last_p[0]  <= in_last;
    relu_p[0]  <= relu_en;
    bias_p[0]  <= bias;
    for (int k = 1; k <= T + 1; k++) begin
      first_p[k] <= first_p[k-1];
      last_p[k]  <= last_p[k-1];
      relu_p[k]  <= relu_p[k-1];
      bias_p[k]  <= bias_p[k-1];
    end
  end

  // ---- stage 1: multipliers; padding lanes up to a power of two are zero
  logic signed [PW-1:0] prod_p1 [NP];

  always_ff @(posedge clk) begin
    for (int i = 0; i < KN; i++) prod_p1[i] <= tap_mul(wei_p0, ima_p0, i);
    for (int i = KN; i < NP; i++) prod_p1[i] <= '0;
  end

  // ---- stages 2..T+1: adder tree, one level per stage, 1-bit growth per level
  for (genvar l = 1; l <= T; l++) begin : g_lvl
    localparam int N  = NP >> l;
    localparam int LW = PW + l;
    logic signed [LW-1:0] s [N];
    if (l == 1) begin : g_leaf
      // Pairwise sum of products (zero pads make an odd leftover pass through).
      always_ff @(posedge clk)
        for (int j = 0; j < N; j++)
          s[j] <= LW'(prod_p1[2*j]) + LW'(prod_p1[2*j+1]);
    end else begin : g_node
      // Pairwise sum of the previous tree level.
      always_ff @(posedge clk)
        for (int j = 0; j < N; j++)
          s[j] <= LW'(g_lvl[l-1].s[2*j]) + LW'(g_lvl[l-1].s[2*j+1]);
    end
  end

  logic signed [SW-1:0]   tree_sum;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_add;
  logic signed [ACCW-1:0] acc_init;
  logic                   acc_open;
  logic                   vld_pa;
  logic                   relu_pa;

  assign tree_sum = g_lvl[T].s[0];

  // Candidate accumulator values: continue the group, or start it with bias.
  always_comb begin
    acc_add  = sat_add(acc, ACCW'(tree_sum));
    acc_init = sat_add(ACCW'(tree_sum), ACCW'(bias_p[T+1]));
  end

  // ---- stage T+2: accumulate, group open/close and protocol checking
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      acc_open <= 1'b0;
      seq_err  <= 1'b0;
      vld_pa   <= 1'b0;
      relu_pa  <= 1'b0;
    end else begin
      vld_pa <= 1'b0;
      if (vld_p[T+1]) begin
        relu_pa <= relu_p[T+1];
        if (first_p[T+1]) begin
          acc      <= acc_init;
          acc_open <= !last_p[T+1];
          vld_pa   <= last_p[T+1];
          if (acc_open) seq_err <= 1'b1;
        end else if (acc_open) begin
          acc      <= acc_add;
          acc_open <= !last_p[T+1];
          vld_pa   <= last_p[T+1];
        end else begin
          seq_err <= 1'b1;
        end
      end
    end
  end

  logic                 vld_ps;
  logic                 sat_ps;
  logic                 relu_ps;
  logic signed [OW-1:0] val_ps;

  // ---- stage T+3: clamp closed group result to OW bits
  always_ff @(posedge clk) begin
    if (rst) vld_ps <= 1'b0;
    else     vld_ps <= vld_pa;
  end

  // Clamp datapath, unreset.
  always_ff @(posedge clk) begin
    {sat_ps, val_ps} <= clamp_ow(acc);
    relu_ps          <= relu_pa;
  end

  // ---- stage T+4: ReLU and output register; data held between results
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= vld_ps;
      if (vld_ps) begin
        if (relu_ps && val_ps[OW-1]) begin
          out_data <= '0;
          out_sat  <= 1'b0;
        end else begin
          out_data <= val_ps;
          out_sat  <= sat_ps;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_acc.sv
// tb_conv_mac_acc: scoreboard bench for conv_mac_acc at default parameters.
module tb_conv_mac_acc;

  localparam int KN   = 49;
  localparam int WW   = 16;
  localparam int IW   = 8;
  localparam int FRAC = 8;
  localparam int OW   = 16;
  localparam int ACCW = 40;
  localparam int L    = 10;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_first;
  logic                  in_last;
  logic [WW*KN-1:0]      wei;
  logic [IW*KN-1:0]      ima;
  logic signed [OW-1:0]  bias;
  logic                  relu_en;
  logic                  out_valid;
  logic signed [OW-1:0]  out_data;
  logic                  out_sat;
  logic                  seq_err;

  conv_mac_acc #(
    .KN(KN), .WW(WW), .IW(IW), .FRAC(FRAC), .OW(OW), .ACCW(ACCW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .wei(wei), .ima(ima), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
    .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    logic          sat;
    int            due;
  } exp_t;

  exp_t   q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint m_acc   = 0;
  bit     m_open  = 1'b0;

  function automatic logic [WW*KN-1:0] rep_w(input logic [WW-1:0] v);
    for (int i = 0; i < KN; i++) rep_w[i*WW +: WW] = v;
  endfunction

  function automatic logic [IW*KN-1:0] rep_x(input logic [IW-1:0] v);
    for (int i = 0; i < KN; i++) rep_x[i*IW +: IW] = v;
  endfunction

  function automatic logic [WW*KN-1:0] rand_w();
    int t;
    for (int i = 0; i < KN; i++) begin
      t = int'($urandom_range(0, 15)) - 8;
      rand_w[i*WW +: WW] = t[WW-1:0];
    end
  endfunction

  function automatic logic [IW*KN-1:0] rand_x();
    for (int i = 0; i < KN; i++) rand_x[i*IW +: IW] = IW'($urandom_range(0, 255));
  endfunction

  function automatic longint acc_sat(input longint a);
    longint lim;
    lim = longint'(1) <<< (ACCW - 1);
    if (a > lim - 1) acc_sat = lim - 1;
    else if (a < -lim) acc_sat = -lim;
    else acc_sat = a;
  endfunction

  function automatic exp_t out_model(input longint a, input bit r);
    exp_t e;
    if (a > 32767) begin
      e.data = 16'h7FFF; e.sat = 1'b1;
    end else if (a < -32768) begin
      e.data = 16'h8000; e.sat = 1'b1;
    end else begin
      e.data = a[15:0]; e.sat = 1'b0;
    end
    if (r && e.data[15]) begin
      e.data = 16'h0000; e.sat = 1'b0;
    end
    e.due = 0;
    return e;
  endfunction

  // Drive one cycle of stimulus and advance the reference model.
  task automatic drive(input bit v, input bit f, input bit l,
                       input logic [WW*KN-1:0] w, input logic [IW*KN-1:0] x,
                       input logic [OW-1:0] b, input bit r);
    longint dot;
    exp_t   e;
    in_valid = v; in_first = f; in_last = l;
    wei = w; ima = x; bias = b; relu_en = r;
    if (v) begin
      dot = 0;
      for (int i = 0; i < KN; i++)
        dot += longint'($signed(w[i*WW +: WW])) * longint'(x[i*IW +: IW]);
      if (f) begin
        m_acc  = acc_sat(dot + longint'($signed(b)));
        m_open = 1'b1;
      end else if (m_open) begin
        m_acc = acc_sat(m_acc + dot);
      end
      if (l && m_open) begin
        m_open = 1'b0;
        e = out_model(m_acc, r);
        e.due = cyc + 1 + L;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rand_w(), rand_x(), 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    q.delete();
    m_open = 1'b0;
    m_acc  = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", q.size());
      q.delete();
    end
  endtask

  // Scoreboard: each out_valid pulse is matched to the oldest expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL spurious_out_valid: got out_data=%h at cycle %0d, required no result", out_data, cyc);
      end else begin
        e = q.pop_front();
        n_tests++;
        if (out_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_out_data: got %h, required %h", out_data, e.data);
        end
        n_tests++;
        if (out_sat !== e.sat) begin
          n_fail++;
          $display("FAIL sb_out_sat: got %b, required %b", out_sat, e.sat);
        end
        n_tests++;
        if (cyc !== e.due) begin
          n_fail++;
          $display("FAIL sb_latency: result at cycle %0d, required cycle %0d", cyc, e.due);
        end
      end
    end else if (q.size() != 0 && cyc > q[0].due) begin
      n_tests++; n_fail++;
      $display("FAIL missing_result: no out_valid at cycle %0d, required %h", q[0].due, q[0].data);
      void'(q.pop_front());
    end
  end

  task automatic test_reset();
    do_reset(3);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_tests++;
    if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0000", out_data); end
    n_tests++;
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %b, required 0", out_sat); end
    n_tests++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err: got %b, required 0", seq_err); end
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 1'b1, rep_w(16'h0100), rep_x(8'd1), 16'h0000, 1'b0);
    wait_drain();
    n_tests++;
    if (out_data !== 16'h3100) begin n_fail++; $display("FAIL single_data: got %h, required 3100", out_data); end
    idle(3);
    n_tests++;
    if (out_data !== 16'h3100 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: got data=%h valid=%b, required data=3100 valid=0", out_data, out_valid);
    end
  endtask

  task automatic test_three_beat();
    drive(1'b1, 1'b1, 1'b0, rep_w(16'h0080), rep_x(8'd1), 16'h0100, 1'b0);
    drive(1'b1, 1'b0, 1'b0, rep_w(16'h0080), rep_x(8'd1), 16'h7777, 1'b0);
    drive(1'b1, 1'b0, 1'b1, rep_w(16'h0080), rep_x(8'd1), 16'h7777, 1'b0);
    wait_drain();
    n_tests++;
    if (out_data !== 16'h4A80) begin n_fail++; $display("FAIL three_beat_data: got %h, required 4A80", out_data); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b1, 1'b1, rep_w(16'h7FFF), rep_x(8'd255), 16'h0000, 1'b0);
    wait_drain();
    n_tests++;
    if (out_data !== 16'h7FFF || out_sat !== 1'b1) begin
      n_fail++; $display("FAIL sat_pos: got %h/%b, required 7FFF/1", out_data, out_sat);
    end
    drive(1'b1, 1'b1, 1'b1, rep_w(16'h8000), rep_x(8'd255), 16'h0000, 1'b0);
    wait_drain();
    n_tests++;
    if (out_data !== 16'h8000 || out_sat !== 1'b1) begin
      n_fail++; $display("FAIL sat_neg: got %h/%b, required 8000/1", out_data, out_sat);
    end
    drive(1'b1, 1'b1, 1'b1, rep_w(16'h8000), rep_x(8'd255), 16'h0000, 1'b1);
    wait_drain();
    n_tests++;
    if (out_data !== 16'h0000 || out_sat !== 1'b0) begin
      n_fail++; $display("FAIL sat_neg_relu: got %h/%b, required 0000/0", out_data, out_sat);
    end
  endtask

  task automatic test_relu();
    drive(1'b1, 1'b1, 1'b1, rep_w(16'hFF00), rep_x(8'd1), 16'h0000, 1'b0);
    wait_drain();
    n_tests++;
    if (out_data !== 16'hCF00) begin n_fail++; $display("FAIL relu_off: got %h, required CF00", out_data); end
    drive(1'b1, 1'b1, 1'b1, rep_w(16'hFF00), rep_x(8'd1), 16'h0000, 1'b1);
    wait_drain();
    n_tests++;
    if (out_data !== 16'h0000) begin n_fail++; $display("FAIL relu_on: got %h, required 0000", out_data); end
  endtask

  task automatic test_back_to_back();
    int nb;
    int t;
    for (int g = 0; g < 40; g++) begin
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        t = int'($urandom_range(0, 1023)) - 512;
        drive(1'b1, b == 0, b == nb - 1, rand_w(), rand_x(), t[15:0], 1'($urandom_range(0, 1)));
      end
    end
    wait_drain();
  endtask

  task automatic test_protocol();
    drive(1'b1, 1'b1, 1'b0, rep_w(16'h0100), rep_x(8'd2), 16'h0010, 1'b0);
    do_reset(1);
    drive(1'b1, 1'b0, 1'b1, rep_w(16'h0100), rep_x(8'd2), 16'h0000, 1'b0);
    in_valid = 1'b0;
    repeat (L + 2) @(negedge clk);
    n_tests++;
    if (seq_err !== 1'b1) begin n_fail++; $display("FAIL orphan_last_seq_err: got %b, required 1", seq_err); end
    drive(1'b1, 1'b1, 1'b1, rep_w(16'h0100), rep_x(8'd2), 16'h0100, 1'b0);
    wait_drain();
    n_tests++;
    if (out_data !== 16'h6300) begin n_fail++; $display("FAIL post_reset_group: got %h, required 6300", out_data); end

    do_reset(2);
    n_tests++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_err_clear: got %b, required 0", seq_err); end
    drive(1'b1, 1'b1, 1'b0, rep_w(16'h0100), rep_x(8'd1), 16'h0500, 1'b0);
    drive(1'b1, 1'b1, 1'b1, rep_w(16'h0100), rep_x(8'd1), 16'h0000, 1'b0);
    wait_drain();
    n_tests++;
    if (out_data !== 16'h3100) begin n_fail++; $display("FAIL restart_data: got %h, required 3100", out_data); end
    n_tests++;
    if (seq_err !== 1'b1) begin n_fail++; $display("FAIL restart_seq_err: got %b, required 1", seq_err); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    wei = '0; ima = '0; bias = '0; relu_en = 1'b0;
    test_reset();
    test_single();
    test_three_beat();
    test_saturation();
    test_relu();
    test_back_to_back();
    test_protocol();
    idle(L + 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_mac_acc.md
# conv_mac_acc

Parametrised, fully pipelined K-tap convolution multiply-accumulate core. It is the successor to the fixed 49-tap conv core and adds three things: configurable tap count and widths, accumulation of partial sums across multiple input channels (beats) before bias and output, and optional ReLU with a saturation flag. It sits between the window/weight buffers and the feature-map writeback in the conv layer datapath.

## Interface
- KN, 49: number of taps (multipliers) per beat, ≥2
- WW, 16: weight width, signed Q(WW-FRAC).FRAC
- IW, 8: pixel width, unsigned integer
- FRAC, 8: fractional bits of weight, bias, accumulator and output
- OW, 16: output width, signed Q(OW-FRAC).FRAC
- ACCW, 40: accumulator width, signed, FRAC fractional bits

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat present this cycle
- in_first  in  1  first beat of a channel group (qualified by in_valid)
- in_last  in  1  last beat of a channel group (qualified by in_valid)
- wei  in  WW*KN  packed weights, tap i at [WW*(i+1)-1:WW*i]
- ima  in  IW*KN  packed pixels, same packing
- bias  in  OW  signed bias Q.FRAC, sampled on in_first beat
- relu_en  in  1  ReLU enable, sampled on in_last beat
- out_valid  out  1  result valid, one-cycle pulse per group
- out_data  out  OW  signed saturated result
- out_sat  out  1  clamp applied to this result
- seq_err  out  1  sticky protocol error flag

## Operation
- Stage 0: register inputs, flags, bias and relu_en alongside in_valid.
- Stage 1: KN multipliers. Product = signed wei × {1'b0, ima}, width WW+IW+1, Q.FRAC. Registered.
- Tree: T = ceil(log2 KN) registered adder stages. Each stage adds pairs with 1-bit growth. An odd leftover is sign-extended and passed through unchanged. Flags, bias and relu_en travel in a matched shift pipeline.
- Accumulate stage. State is an `open` flag plus the ACCW accumulator.
  - in_first: acc ← sext(sum) + sext(bias); open ← 1.
  - Non-first beat with open=1: acc ← acc + sext(sum).
  - Accumulator additions saturate at ACCW signed limits. There is no wrap-around.
  - in_last (with open, or with in_first): the group closes; open ← 0; the result is forwarded to the output stage.
- Output stage:
  - acc > 2^(OW-1)-1 → 2^(OW-1)-1, out_sat=1.
  - acc < -2^(OW-1) → -2^(OW-1), out_sat=1.
  - Otherwise acc[OW-1:0], out_sat=0.
  - Then, if relu_en and the result is negative: out_data=0, out_sat=0.
- in_first and in_last on the same beat form a single-beat group.
- in_first while open=1: the old partial is discarded, the group restarts, and seq_err is set.
- Non-first beat while open=0 (including the first beat after reset): the beat is ignored, no output is produced, and seq_err is set.
- in_valid=0 cycles are bubbles. There is no backpressure and no stall; the pipeline always advances.

## Timing
- Latency L = T + 4 cycles, measured from the in_last beat's input edge to out_valid. This is L=10 at KN=49.
- One beat is accepted per cycle. Groups may be back-to-back: the next in_first can arrive the cycle after in_last.
- out_valid pulses for exactly one cycle per closed group. out_data and out_sat are held until the next result.
- Reset values: out_valid=0, out_data=0, out_sat=0, seq_err=0, acc=0, open=0, all pipeline valids=0.
- Reset mid-operation: in-flight beats and partial sums are dropped and no out_valid is produced for them. The first beat after reset must carry in_first.
- seq_err is cleared only by rst.

## Test plan
- Single beat: all wei=0x0100, all ima=1, bias=0, first=last=1 → out_data=0x3100, out_sat=0, out_valid exactly 10 cycles later, one cycle wide.
- Three-beat group: wei=0x0080, ima=1, bias=0x0100 on the first beat, last on beat 3 → a single out_valid, out_data=0x4A80 (74.5), 10 cycles after beat 3.
- Saturation:
  - wei=0x7FFF, ima=255 → 0x7FFF, out_sat=1.
  - wei=0x8000, ima=255 → 0x8000, out_sat=1.
  - Same negative case with relu_en=1 → 0x0000, out_sat=0.
- ReLU: wei=0xFF00, ima=1, bias=0 → relu_en=0 gives 0xCF00; relu_en=1 gives 0x0000.
- Streaming: groups back-to-back and interleaved with random in_valid=0 bubbles, compared against a reference model → results in order, each exactly L after its last beat.
- Protocol and reset:
  - in_first beat, then rst for 1 cycle, then a beat with only in_last → no out_valid, seq_err=1.
  - A following correct group → correct out_data.
  - in_first during an open group → restart, seq_err=1.
